ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, in parallel with the ALU.
- Consumes the same final operands the ALU uses: Alu_in1 and Alu_in2, where Alu_in2 is the output of the immediate/R2 select.
- Raises busy to stall IF/ID/EX while it iterates. Presents a 32-bit result with a one-cycle done pulse for the EX/MEM register to capture.

---
 rtl/ex_muldiv_unit_if.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Operand/handshake bundle between the EX stage and the multiply/divide unit.
// master drives the operation request; slave is the unit itself.
interface ex_muldiv_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] Alu_in1;
   logic [XLEN-1:0] Alu_in2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] MulDiv_result;

   modport master (
      output start, funct3, Alu_in1, Alu_in2, flush,
      input  busy, done, MulDiv_result
   );

   modport slave (
      input  start, funct3, Alu_in1, Alu_in2, flush,
      output busy, done, MulDiv_result
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle.
// Define MULDIV_SINGLE_CYCLE_MUL_EN to compute multiplies in the issue cycle instead.
module ex_muldiv_unit #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ITER_W = 6
) (
   input logic               clk,
   input logic               rst,
   ex_muldiv_unit_if.slave   bus
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

   state_e            state;
   logic [ITER_W-1:0] count;
   logic [2:0]        f3_q;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;
   logic              neg;
   logic              rem_neg;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   logic              a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              special;
   logic [XLEN-1:0]   special_res;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, prod;
   logic [XLEN:0]     div_shift, div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   mul_res, div_res, quo, rem;
   logic              last;

   always_comb begin
      a_signed = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
      b_signed = bus.funct3 inside {3'b001, 3'b100, 3'b110};
      sa       = a_signed & bus.Alu_in1[XLEN-1];
      sb       = b_signed & bus.Alu_in2[XLEN-1];
      mag_a    = sa ? -bus.Alu_in1 : bus.Alu_in1;
      mag_b    = sb ? -bus.Alu_in2 : bus.Alu_in2;

      // Divide-by-zero and signed overflow finish without iterating.
      special     = 1'b0;
      special_res = '0;
      if (bus.Alu_in2 == '0) begin
         special     = 1'b1;
         special_res = bus.funct3[1] ? bus.Alu_in1 : '1;
      end else if (b_signed && bus.Alu_in1 == {1'b1, {(XLEN-1){1'b0}}} && bus.Alu_in2 == '1) begin
         special     = 1'b1;
         special_res = bus.funct3[1] ? '0 : bus.Alu_in1;
      end
   end

   always_comb begin
      // Shift-add: low half of acc holds the remaining multiplier bits.
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
      prod     = neg ? -mul_next : mul_next;
      mul_res  = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

      // Restoring divide: high half is the partial remainder, low half the quotient.
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      div_next  = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                   acc[XLEN-2:0], ~div_diff[XLEN]};
      quo       = div_next[XLEN-1:0];
      rem       = div_next[2*XLEN-1:XLEN];
      div_res   = f3_q[1] ? (rem_neg ? -rem : rem) : (neg ? -quo : quo);

      last = (count == ITER_W'(XLEN - 1));
   end

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]   fast_res;

   always_comb begin
      fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
      if (sa ^ sb) fast_prod = -fast_prod;
      fast_res = (bus.funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         count    <= '0;
         f3_q     <= '0;
         acc      <= '0;
         opb      <= '0;
         neg      <= 1'b0;
         rem_neg  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            StIdle: begin
               if (bus.start && !bus.flush) begin
                  f3_q    <= bus.funct3;
                  neg     <= sa ^ sb;
                  rem_neg <= sa;
                  count   <= '0;
                  if (bus.funct3[2] && special) begin
                     result_q <= special_res;
                     done_q   <= 1'b1;
                     state    <= StFin;
                  end else if (bus.funct3[2]) begin
                     acc   <= {{XLEN{1'b0}}, mag_a};
                     opb   <= mag_b;
                     state <= StDiv;
                  end else begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                     result_q <= fast_res;
                     done_q   <= 1'b1;
                     state    <= StFin;
`else
                     acc   <= {{XLEN{1'b0}}, mag_b};
                     opb   <= mag_a;
                     state <= StMul;
`endif
                  end
               end
            end
            StMul: begin
               if (bus.flush) begin
                  state <= StIdle;
               end else begin
                  acc   <= mul_next;
                  count <= count + 1'b1;
                  if (last) begin
                     result_q <= mul_res;
                     done_q   <= 1'b1;
                     state    <= StFin;
                  end
               end
            end
            StDiv: begin
               if (bus.flush) begin
                  state <= StIdle;
               end else begin
                  acc   <= div_next;
                  count <= count + 1'b1;
                  if (last) begin
                     result_q <= div_res;
                     done_q   <= 1'b1;
                     state    <= StFin;
                  end
               end
            end
            StFin:   state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.busy = (bus.start && state == StIdle && !bus.flush) ||
                     state == StMul || state == StDiv;
   assign bus.done          = done_q;
   assign bus.MulDiv_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized bench for ex_muldiv_unit against an arithmetic reference model.
// Honours MULDIV_SINGLE_CYCLE_MUL_EN for expected multiply latency.
module tb_ex_muldiv_unit;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit_if #(.XLEN(32)) bus ();

   ex_muldiv_unit #(.XLEN(32), .ITER_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      x, y;
      logic [63:0] p;
      int          sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin x = longint'(sa); y = longint'(sb); p = x * y; return p[63:32]; end
         3'd2: begin x = longint'(sa); y = {32'b0, b}; p = x * y; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
      if (!f3[2]) return 1;
`endif
      return 33;
   endfunction

   // Issue in the current cycle, scribble ignored starts while busy, check timing and result.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int          lat, k;
      bit          seen, busy_ok;
      exp = ref_md(f3, a, b);
      lat = ref_lat(f3, a, b);
      bus.start = 1'b1; bus.funct3 = f3; bus.Alu_in1 = a; bus.Alu_in2 = b; bus.flush = 1'b0;
      #1;
      chk("busy_issue", 64'(bus.busy), 64'd1);
      tick();
      k = 1; seen = 1'b0; busy_ok = 1'b1;
      while (!seen && k <= 40) begin
         bus.start   = 1'($urandom_range(0, 1));
         bus.funct3  = 3'($urandom);
         bus.Alu_in1 = $urandom;
         bus.Alu_in2 = $urandom;
         #1;
         if (bus.done) seen = 1'b1;
         else begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            k++;
         end
      end
      chk("latency", seen ? 64'(k) : 64'd0, 64'(lat));
      chk("busy_run", 64'(busy_ok), 64'd1);
      chk("result", 64'(bus.MulDiv_result), 64'(exp));
      chk("busy_fin", 64'(bus.busy), 64'd0);
      bus.start = 1'b0;
      tick();
      chk("done_pulse", 64'(bus.done), 64'd0);
      chk("hold", 64'(bus.MulDiv_result), 64'(exp));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] prev;
      bit          early_done;
      rst = 1'b1;
      bus.start = 1'b0; bus.funct3 = '0; bus.Alu_in1 = '0; bus.Alu_in2 = '0; bus.flush = 1'b0;
      tick();
      tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_result", 64'(bus.MulDiv_result), 64'd0);
      rst = 1'b0;
      tick();

      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd5, 32'd100, 32'd7);
      run_op(3'd7, 32'd100, 32'd7);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd4, 32'h0000_1234, 32'd0);
      run_op(3'd7, 32'h0000_1234, 32'd0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      // start together with flush must not be accepted
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5; bus.Alu_in1 = 32'd9; bus.Alu_in2 = 32'd2;
      #1;
      chk("startflush_busy", 64'(bus.busy), 64'd0);
      tick();
      bus.start = 1'b0; bus.flush = 1'b0;
      #1;
      chk("startflush_idle", 64'(bus.busy), 64'd0);
      tick();
      chk("startflush_done", 64'(bus.done), 64'd0);

      // flush mid-divide: back to idle, no done, result untouched
      prev = bus.MulDiv_result;
      bus.start = 1'b1; bus.funct3 = 3'd5; bus.Alu_in1 = 32'd1000; bus.Alu_in2 = 32'd3;
      tick();
      bus.start = 1'b0;
      early_done = 1'b0;
      for (int i = 1; i < 10; i++) begin
         if (bus.done) early_done = 1'b1;
         tick();
      end
      bus.flush = 1'b1;
      #1;
      chk("flush_busy_before", 64'(bus.busy), 64'd1);
      tick();
      bus.flush = 1'b0;
      #1;
      chk("flush_busy_after", 64'(bus.busy), 64'd0);
      chk("flush_no_done", 64'(bus.done | early_done), 64'd0);
      chk("flush_result", 64'(bus.MulDiv_result), 64'(prev));
      run_op(3'd5, 32'd100, 32'd7);

      for (int n = 0; n < 60; n++) run_op(3'($urandom), pick(), pick());

      // async reset mid-multiply clears outputs without waiting for an edge
      run_op(3'd0, 32'd3, 32'd5);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.Alu_in1 = 32'd11; bus.Alu_in2 = 32'd13;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_result", 64'(bus.MulDiv_result), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_idle_busy", 64'(bus.busy), 64'd0);
      chk("arst_idle_done", 64'(bus.done), 64'd0);
      run_op(3'd0, 32'd11, 32'd13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
